ex_mem_stage: RTL and testbench

- EX/MEM pipeline register directly downstream of the ID/EX stage. It captures the 22-bit control word forwarded through EX, plus the ALU result, store data and destination register, and presents them to the MEM stage.
- Load/store instructions are held with a req/ready handshake against data memory. While memory is busy, the block back-pressures EX and everything upstream.
- It also handles pipeline flushes and keeps memory-wait diagnostics.

---
 rtl/ex_mem_stage.sv | 132 +++++++++++++
 tb/tb_ex_mem_stage.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures the EX control word and datapath fields for the MEM stage.
// Latency: 1 cycle from EX to the MEM-facing outputs; mem_req is registered alongside the slot.
// Backpressure: stall_out is high while a load/store waits for mem_ready and EX must hold its outputs.
module ex_mem_stage #(
    parameter int CTRL_W  = 22,
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int LD_BIT  = 0,
    parameter int ST_BIT  = 1,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [CTRL_W-1:0] ex_ctrl,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              flush,
    input  logic              mem_ready,
    output logic              stall_out,
    output logic              mem_valid,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [REG_W-1:0]  mem_rd,
    output logic              mem_req,
    output logic              mem_timeout,
    output logic [15:0]       stall_cycles
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_PASS  = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             pending_flush_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_inc;
    logic             accept;
    logic             eff_flush;
    logic             take_bubble;
    logic             is_mem;

    always_comb begin
        accept      = (state_q != S_WAIT) | mem_ready;
        eff_flush   = flush | pending_flush_q;
        take_bubble = eff_flush | ~ex_valid;
        is_mem      = ex_ctrl[LD_BIT] | ex_ctrl[ST_BIT];
        state_d     = state_q;
        if (accept) begin
            if (take_bubble) begin
                // A squashed instruction still occupies the slot as a bubble.
                state_d = (eff_flush | ex_valid) ? S_PASS : S_EMPTY;
            end else begin
                state_d = is_mem ? S_WAIT : S_PASS;
            end
        end
    end

    assign stall_out    = ~accept;
    assign wait_cnt_inc = (wait_cnt_q == TMO_CNT) ? wait_cnt_q : wait_cnt_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_valid      <= 1'b0;
            mem_ctrl       <= '0;
            mem_alu_result <= '0;
            mem_store_data <= '0;
            mem_rd         <= '0;
            mem_req        <= 1'b0;
        end else if (accept) begin
            mem_req <= (state_d == S_WAIT);
            if (take_bubble) begin
                mem_valid      <= 1'b0;
                mem_ctrl       <= '0;
                mem_alu_result <= '0;
                mem_store_data <= '0;
                mem_rd         <= '0;
            end else begin
                mem_valid      <= 1'b1;
                mem_ctrl       <= ex_ctrl;
                mem_alu_result <= ex_alu_result;
                mem_store_data <= ex_store_data;
                mem_rd         <= ex_rd;
            end
        end
    end

    // A flush seen while stalled is remembered and applied to the instruction accepted next.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_flush_q <= 1'b0;
            wait_cnt_q      <= '0;
            mem_timeout     <= 1'b0;
        end else if (accept) begin
            pending_flush_q <= 1'b0;
            wait_cnt_q      <= '0;
        end else begin
            if (flush) begin
                pending_flush_q <= 1'b1;
            end
            wait_cnt_q <= wait_cnt_inc;
            if (wait_cnt_inc == TMO_CNT) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (stall_out && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus random traffic against a cycle-level reference model.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ex_valid = 1'b0;
    logic [21:0] ex_ctrl = '0;
    logic [31:0] ex_alu_result = '0;
    logic [31:0] ex_store_data = '0;
    logic [4:0]  ex_rd = '0;
    logic        flush = 1'b0;
    logic        mem_ready = 1'b0;
    logic        stall_out;
    logic        mem_valid;
    logic [21:0] mem_ctrl;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_store_data;
    logic [4:0]  mem_rd;
    logic        mem_req;
    logic        mem_timeout;
    logic [15:0] stall_cycles;

    int n_checks = 0;
    int n_fail = 0;

    ex_mem_stage dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .flush(flush), .mem_ready(mem_ready), .stall_out(stall_out), .mem_valid(mem_valid),
        .mem_ctrl(mem_ctrl), .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
        .mem_rd(mem_rd), .mem_req(mem_req), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Reference model: what the MEM stage should see, tracked per cycle.
    bit          m_valid;
    logic [21:0] m_ctrl;
    logic [31:0] m_alu;
    logic [31:0] m_st;
    logic [4:0]  m_rd;
    bit          m_waiting;
    bit          m_pend;
    bit          m_to;
    int          m_cnt;
    int          m_stalls;

    function automatic void model_reset();
        m_valid = 0; m_ctrl = '0; m_alu = '0; m_st = '0; m_rd = '0;
        m_waiting = 0; m_pend = 0; m_to = 0; m_cnt = 0; m_stalls = 0;
    endfunction

    function automatic bit model_stall();
        return m_waiting && !mem_ready;
    endfunction

    function automatic void model_edge();
        if (model_stall()) begin
            if (flush) m_pend = 1;
            if (m_cnt < 15) m_cnt++;
            if (m_cnt == 15) m_to = 1;
            if (m_stalls < 65535) m_stalls++;
        end else begin
            if (flush || m_pend || !ex_valid) begin
                m_valid = 0; m_ctrl = '0; m_alu = '0; m_st = '0; m_rd = '0;
                m_waiting = 0;
            end else begin
                m_valid = 1; m_ctrl = ex_ctrl; m_alu = ex_alu_result;
                m_st = ex_store_data; m_rd = ex_rd;
                m_waiting = ex_ctrl[0] || ex_ctrl[1];
            end
            m_pend = 0;
            m_cnt = 0;
        end
    endfunction

    function automatic logic [109:0] exp_vec();
        return {m_valid, m_ctrl, m_alu, m_st, m_rd, m_waiting, m_to, 16'(m_stalls)};
    endfunction

    function automatic logic [109:0] dut_vec();
        return {mem_valid, mem_ctrl, mem_alu_result, mem_store_data, mem_rd,
                mem_req, mem_timeout, stall_cycles};
    endfunction

    task automatic drive(input logic v, input logic [21:0] c, input logic [31:0] a,
                         input logic [31:0] s, input logic [4:0] r, input logic f,
                         input logic rdy);
        ex_valid = v; ex_ctrl = c; ex_alu_result = a; ex_store_data = s;
        ex_rd = r; flush = f; mem_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        @(negedge clk);
        n_checks++;
        if (dut_vec() !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", dut_vec());
        end
        n_checks++;
        if (stall_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b want 0", stall_out);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        drive(1, 22'h000004, 32'h10, 32'h0, 5'd3, 0, 0);
        #1;
        n_checks++;
        if (stall_out !== 1'b0) begin
            n_fail++; $display("FAIL basic_stall: got %b want 0", stall_out);
        end
        tick();
        n_checks++;
        if ({mem_valid, mem_ctrl, mem_alu_result, mem_rd, mem_req} !== {1'b1, 22'h4, 32'h10, 5'd3, 1'b0}) begin
            n_fail++; $display("FAIL basic_capture: got v=%b c=%h a=%h rd=%0d req=%b want v=1 c=4 a=10 rd=3 req=0",
                               mem_valid, mem_ctrl, mem_alu_result, mem_rd, mem_req);
        end
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL basic_model: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_load_wait();
        drive(1, 22'h000001, 32'h100, 32'hDEAD, 5'd7, 0, 0);
        tick();
        n_checks++;
        if (mem_req !== 1'b1 || mem_alu_result !== 32'h100) begin
            n_fail++; $display("FAIL load_issue: got req=%b a=%h want req=1 a=100", mem_req, mem_alu_result);
        end
        drive(1, 22'h000008, 32'h44, 32'h0, 5'd9, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (stall_out !== 1'b1) begin
                n_fail++; $display("FAIL load_stall_%0d: got %b want 1", i, stall_out);
            end
            tick();
            n_checks++;
            if ({mem_req, mem_ctrl, mem_alu_result, mem_rd} !== {1'b1, 22'h1, 32'h100, 5'd7}) begin
                n_fail++; $display("FAIL load_hold_%0d: got req=%b c=%h a=%h rd=%0d want req=1 c=1 a=100 rd=7",
                                   i, mem_req, mem_ctrl, mem_alu_result, mem_rd);
            end
        end
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if (stall_out !== 1'b0) begin
            n_fail++; $display("FAIL load_ready_stall: got %b want 0", stall_out);
        end
        tick();
        n_checks++;
        if ({mem_ctrl, mem_req, stall_cycles} !== {22'h8, 1'b0, 16'd3}) begin
            n_fail++; $display("FAIL load_complete: got c=%h req=%b stalls=%0d want c=8 req=0 stalls=3",
                               mem_ctrl, mem_req, stall_cycles);
        end
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL load_model: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_flush();
        drive(1, 22'h000002, 32'h200, 32'h55, 5'd0, 0, 0);
        tick();
        drive(1, 22'h000010, 32'h300, 32'h0, 5'd4, 1, 0);
        tick();
        n_checks++;
        if (mem_req !== 1'b1 || mem_alu_result !== 32'h200) begin
            n_fail++; $display("FAIL flush_keeps_access: got req=%b a=%h want req=1 a=200", mem_req, mem_alu_result);
        end
        flush = 1'b0;
        tick();
        mem_ready = 1'b1;
        tick();
        n_checks++;
        if ({mem_valid, mem_ctrl, mem_req} !== {1'b0, 22'h0, 1'b0}) begin
            n_fail++; $display("FAIL flush_pending_bubble: got v=%b c=%h req=%b want v=0 c=0 req=0",
                               mem_valid, mem_ctrl, mem_req);
        end
        tick();
        n_checks++;
        if ({mem_valid, mem_ctrl} !== {1'b1, 22'h10}) begin
            n_fail++; $display("FAIL flush_pending_cleared: got v=%b c=%h want v=1 c=10", mem_valid, mem_ctrl);
        end
        flush = 1'b1;
        tick();
        n_checks++;
        if ({mem_valid, mem_ctrl, mem_rd} !== {1'b0, 22'h0, 5'd0}) begin
            n_fail++; $display("FAIL flush_immediate: got v=%b c=%h rd=%0d want v=0 c=0 rd=0",
                               mem_valid, mem_ctrl, mem_rd);
        end
        drive(0, 22'h0, 32'h0, 32'h0, 5'd0, 0, 0);
        tick();
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL flush_model: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 22'h000002, 32'h400, 32'hAAAA, 5'd0, 0, 0);
        tick();
        drive(1, 22'h000002, 32'h500, 32'hBBBB, 5'd0, 0, 1);
        tick();
        n_checks++;
        if ({mem_req, mem_alu_result, mem_store_data} !== {1'b1, 32'h500, 32'hBBBB}) begin
            n_fail++; $display("FAIL b2b_second: got req=%b a=%h s=%h want req=1 a=500 s=bbbb",
                               mem_req, mem_alu_result, mem_store_data);
        end
        drive(0, 22'h0, 32'h0, 32'h0, 5'd0, 0, 1);
        tick();
        n_checks++;
        if ({mem_req, mem_valid} !== 2'b00) begin
            n_fail++; $display("FAIL b2b_done: got req=%b v=%b want 0 0", mem_req, mem_valid);
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_timeout();
        drive(1, 22'h000001, 32'h600, 32'h0, 5'd1, 0, 0);
        tick();
        ex_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            n_checks++;
            if (mem_timeout !== (i >= 15)) begin
                n_fail++; $display("FAIL timeout_wait_%0d: got %b want %b", i, mem_timeout, (i >= 15));
            end
        end
        mem_ready = 1'b1;
        tick();
        n_checks++;
        if (mem_timeout !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL timeout_sticky: got to=%b req=%b want to=1 req=0", mem_timeout, mem_req);
        end
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL timeout_model: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 22'($urandom()), 32'($urandom()), 32'($urandom()),
                  5'($urandom()), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 4) < 2));
            #1;
            n_checks++;
            if (stall_out !== model_stall()) begin
                n_fail++; $display("FAIL rand_stall_%0d: got %b want %b", i, stall_out, model_stall());
            end
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL rand_slot_%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1, 22'h000001, 32'h700, 32'h0, 5'd2, 0, 1);
        tick();
        mem_ready = 1'b0;
        ex_valid = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({mem_req, mem_valid, mem_timeout, stall_cycles} !== {1'b0, 1'b0, 1'b0, 16'd0}) begin
            n_fail++; $display("FAIL async_reset: got req=%b v=%b to=%b stalls=%0d want all 0",
                               mem_req, mem_valid, mem_timeout, stall_cycles);
        end
        n_checks++;
        if (dut_vec() !== exp_vec() || stall_out !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_all: got %h stall=%b want %h stall=0", dut_vec(), stall_out, exp_vec());
        end
        @(negedge clk);
        reset = 1'b1;
        drive(1, 22'h000020, 32'h800, 32'h0, 5'd6, 0, 0);
        tick();
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL post_reset_capture: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_load_wait();
        test_flush();
        test_back_to_back();
        test_timeout();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
